decode_layer: RTL and testbench
===============================

// Module: decode_layer
// PURPOSE
//  Consumer end of the fetch_layer instruction stream. Decodes each 12-bit instruction, sequences layer
//  execution over the batch (one start/done handshake per sample) and drives stop back to the fetch
//  stage. Fetch advances only while stop is low.
// PARAMETERS
//  instruction_size  12  instruction width; opcode = [11:8], operand = [7:0]
//  max_batch_size    3   samples per FORWARD instruction (>=1)
//  layer_id_width    4   width of layer_id (operand[7:4])
// PORTS
//  clk                input   1   rising-edge clock, single clock domain
//  reset              input   1   asynchronous, active-high reset
//  instruction        input   instruction_size  instruction from fetch_layer
//  instruction_valid  input   1   instruction holds a fetched word (low after reset until first fetch)
//  stop               output  1   to fetch_layer: hold current instruction, do not advance
//  layer_start        output  1   one-cycle pulse: start layer_id on sample_index
//  layer_id           output  layer_id_width   target layer, latched from operand[7:4]
//  sample_index       output  $clog2(max_batch_size) (min 1)  sample being processed
//  layer_done         input   1   one-cycle pulse from the layer: current sample finished
//  busy               output  1   high in ISSUE or WAIT_DONE
//  halted             output  1   high in HALTED
//  illegal_op         output  1   sticky: an undefined opcode was decoded
// BEHAVIOUR
//  Reset: state=IDLE; layer_start=0, layer_id=0, sample_index=0, busy=0, halted=0, illegal_op=0.
//   stop is forced to 0 while reset is high.
//  Opcodes: 0000 NOP, 0001 FORWARD, 0010 HALT, all others are illegal.
//  States: IDLE, ISSUE, WAIT_DONE, HALTED.
//  IDLE:
//   - instruction_valid=0 or NOP: stop=0, stay in IDLE.
//   - FORWARD: stop=1 combinationally in the same cycle. Latch layer_id, set sample_index=0, go to ISSUE.
//   - HALT: stop=1, go to HALTED.
//   - illegal: set illegal_op, treat as NOP (stop=0, stay in IDLE).
//  ISSUE: layer_start=1 for exactly this cycle, stop=1, go to WAIT_DONE.
//  WAIT_DONE:
//   - stop=1 until the final layer_done.
//   - layer_done with sample_index < max_batch_size-1: increment sample_index, go to ISSUE.
//   - layer_done with sample_index = max_batch_size-1: stop=0 in that same cycle, so fetch advances
//     exactly once. sample_index wraps to 0, go to IDLE.
//  HALTED: stop=1, halted=1 until reset. instruction and layer_done are ignored.
//  stop is combinational from state, instruction, instruction_valid and layer_done. All other outputs
//   are registered.
//  The held instruction is never decoded twice: stop deasserts only in the cycle fetch loads the next word.
//  Boundaries:
//   - layer_done outside WAIT_DONE is ignored. It does not change sample_index.
//   - layer_done in the same cycle as layer_start cannot occur. The layer responds no earlier than the
//     next cycle; ISSUE ignores layer_done.
//   - max_batch_size=1: every layer_done is the final one.
//   - Reset mid-operation (any state): immediate return to IDLE and all outputs reset. Any layer still
//     running is abandoned; its later layer_done is ignored.
//   - illegal_op clears only on reset.
// STRUCTURE
//  Shared package neural_burning_pkg holds:
//   - opcode localparams OP_NOP=4'b0000, OP_FORWARD=4'b0001, OP_HALT=4'b0010
//   - OPCODE_MSB=11, OPCODE_LSB=8
//   - the decode_state_t enum {IDLE, ISSUE, WAIT_DONE, HALTED}, also used by fetch_layer and the layers
//  One natural sub-module: batch_counter (clear, increment, last flag, parameterised by max_batch_size).
//   The FSM and stop logic stay in decode_layer.
// TESTING
//  1. reset=1 then release with instruction_valid=0 -> stop=0, busy=0, no layer_start for 10 cycles.
//  2. FORWARD 12'h1_30, done returned 2 cycles after each start -> 3 layer_start pulses, layer_id=3,
//     sample_index 0,1,2. stop high from decode cycle to last done; stop=0 on exactly that cycle.
//  3. Program {FORWARD, FORWARD, HALT} as held by fetch -> 6 starts total, each instruction consumed once,
//     then halted=1, stop=1 held 20 cycles.
//  4. Opcode 4'b0111 -> illegal_op=1 next cycle, stop=0, no layer_start. A following NOP leaves illegal_op=1.
//  5. Assert reset asynchronously mid-WAIT_DONE (sample_index=1) -> outputs reset before next edge.
//     A stale layer_done after release is ignored. FORWARD re-runs from sample 0.
//  6. Spurious layer_done in IDLE and ISSUE -> no state or sample_index change. Repeat test 2 with
//     max_batch_size=1 -> single start; stop drops on first done.

Source files
------------

// File: rtl/neural_burning_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neural_burning_pkg
//  Description : Shared definitions for the fetch/decode/layer pipeline:
//                opcode encodings, opcode field position, decode state type
//                and a width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package neural_burning_pkg;

   localparam logic [3:0] OP_NOP     = 4'b0000;
   localparam logic [3:0] OP_FORWARD = 4'b0001;
   localparam logic [3:0] OP_HALT    = 4'b0010;

   localparam int OPCODE_MSB = 11;
   localparam int OPCODE_LSB = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      HALTED    = 2'd3
   } decode_state_t;

   // Counter width for n states; a single-state counter still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_layer_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_layer_if
//  Description : Instruction stream and layer control bundle between the
//                decode stage and its environment (fetch stage and layers).
//                slave  : decode_layer side
//                master : fetch/layer side
//  Ports       : instruction, instruction_valid, layer_done  (to decoder)
//                stop, layer_start, layer_id, sample_index,
//                busy, halted, illegal_op                    (from decoder)
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_layer_if #(
   parameter int INSTRUCTION_SIZE = 12,
   parameter int LAYER_ID_WIDTH   = 4,
   parameter int SAMPLE_WIDTH     = 2
);
   logic [INSTRUCTION_SIZE-1:0] instruction;
   logic                        instruction_valid;
   logic                        stop;
   logic                        layer_start;
   logic [LAYER_ID_WIDTH-1:0]   layer_id;
   logic [SAMPLE_WIDTH-1:0]     sample_index;
   logic                        layer_done;
   logic                        busy;
   logic                        halted;
   logic                        illegal_op;

   modport slave (
      input  instruction, instruction_valid, layer_done,
      output stop, layer_start, layer_id, sample_index, busy, halted, illegal_op
   );

   modport master (
      output instruction, instruction_valid, layer_done,
      input  stop, layer_start, layer_id, sample_index, busy, halted, illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/decode_layer_batch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : batch_counter
//  Description : Sample index counter for one FORWARD batch. Clear has
//                priority over increment; incrementing on the last sample
//                wraps back to zero.
//  Ports       : clk, reset (async, active-high), clear, incr,
//                count (current sample), last (count == MAX_BATCH_SIZE-1)
//  Revision    : 1.0  initial release
// ============================================================================
module batch_counter
   import neural_burning_pkg::*;
#(
   parameter int MAX_BATCH_SIZE = 3,
   parameter int COUNT_WIDTH    = clog2_min1(MAX_BATCH_SIZE)
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   input  wire logic                   clear,
   input  wire logic                   incr,
   output      logic [COUNT_WIDTH-1:0] count,
   output      logic                   last
);

   localparam logic [COUNT_WIDTH-1:0] LAST_VALUE = COUNT_WIDTH'(MAX_BATCH_SIZE - 1);

   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (incr) begin
         count_d = (count_q == LAST_VALUE) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign last  = (count_q == LAST_VALUE);

endmodule
`default_nettype wire

// File: rtl/decode_layer.sv
`default_nettype none
// ============================================================================
//  Module      : decode_layer
//  Description : Consumer end of the fetch instruction stream. Decodes NOP,
//                FORWARD and HALT, runs one layer_start/layer_done handshake
//                per sample of a FORWARD batch and holds the fetch stage with
//                stop while an instruction is being executed.
//  Ports       : clk, reset (async, active-high)
//                bus (decode_layer_if.slave): instruction, instruction_valid,
//                layer_done in; stop (combinational), layer_start, layer_id,
//                sample_index, busy, halted, illegal_op (registered) out
//  Revision    : 1.0  initial release
// ============================================================================
module decode_layer
   import neural_burning_pkg::*;
#(
   parameter int INSTRUCTION_SIZE = 12,
   parameter int MAX_BATCH_SIZE   = 3,
   parameter int LAYER_ID_WIDTH   = 4
) (
   input wire logic      clk,
   input wire logic      reset,
   decode_layer_if.slave bus
);

   localparam int SAMPLE_WIDTH = clog2_min1(MAX_BATCH_SIZE);
   // layer_id sits at the top of the operand, directly below the opcode.
   localparam int LAYER_ID_MSB = OPCODE_LSB - 1;

   decode_state_t state_q, state_d;

   logic                      layer_start_q, layer_start_d;
   logic [LAYER_ID_WIDTH-1:0] layer_id_q,    layer_id_d;
   logic                      busy_q,        busy_d;
   logic                      halted_q,      halted_d;
   logic                      illegal_op_q,  illegal_op_d;

   logic                        stop_w;
   logic                        cnt_clear_w;
   logic                        cnt_incr_w;
   logic                        cnt_last_w;
   logic [SAMPLE_WIDTH-1:0]     cnt_w;
   logic [INSTRUCTION_SIZE-1:0] instr_w;
   logic [3:0]                  opcode_w;
   logic                        unused_instr_bits;

   assign instr_w  = bus.instruction;
   assign opcode_w = instr_w[OPCODE_MSB:OPCODE_LSB];
   // Low operand bits carry no meaning for the supported opcodes.
   assign unused_instr_bits = ^instr_w;

   batch_counter #(
      .MAX_BATCH_SIZE (MAX_BATCH_SIZE),
      .COUNT_WIDTH    (SAMPLE_WIDTH)
   ) u_batch_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear_w),
      .incr  (cnt_incr_w),
      .count (cnt_w),
      .last  (cnt_last_w)
   );

   always_comb begin
      state_d      = state_q;
      stop_w       = 1'b0;
      layer_id_d   = layer_id_q;
      illegal_op_d = illegal_op_q;
      cnt_clear_w  = 1'b0;
      cnt_incr_w   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.instruction_valid) begin
               case (opcode_w)
                  OP_NOP: begin
                  end
                  OP_FORWARD: begin
                     // Hold fetch in the decode cycle so the word is not lost.
                     stop_w      = 1'b1;
                     layer_id_d  = instr_w[LAYER_ID_MSB -: LAYER_ID_WIDTH];
                     cnt_clear_w = 1'b1;
                     state_d     = ISSUE;
                  end
                  OP_HALT: begin
                     stop_w  = 1'b1;
                     state_d = HALTED;
                  end
                  default: begin
                     // Undefined opcode: flag it and let fetch move on.
                     illegal_op_d = 1'b1;
                  end
               endcase
            end
         end
         ISSUE: begin
            // The layer cannot answer in its start cycle; layer_done is ignored.
            stop_w  = 1'b1;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            stop_w = 1'b1;
            if (bus.layer_done) begin
               cnt_incr_w = 1'b1;
               if (cnt_last_w) begin
                  // Release fetch in exactly the cycle the batch completes,
                  // so the next word is loaded once and decoded in IDLE.
                  stop_w  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         HALTED: begin
            stop_w = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered outputs are derived from the next state so they are
      // valid throughout the cycle the FSM spends in that state.
      layer_start_d = (state_d == ISSUE);
      busy_d        = (state_d == ISSUE) || (state_d == WAIT_DONE);
      halted_d      = (state_d == HALTED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         layer_start_q <= 1'b0;
         layer_id_q    <= '0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
         illegal_op_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         layer_start_q <= layer_start_d;
         layer_id_q    <= layer_id_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
         illegal_op_q  <= illegal_op_d;
      end
   end

   // stop is forced low for as long as reset is held.
   assign bus.stop         = stop_w & ~reset;
   assign bus.layer_start  = layer_start_q;
   assign bus.layer_id     = layer_id_q;
   assign bus.sample_index = cnt_w;
   assign bus.busy         = busy_q;
   assign bus.halted       = halted_q;
   assign bus.illegal_op   = illegal_op_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_layer
//  Description : Self-checking bench for decode_layer. A fetch model feeds a
//                program while stop is low, a layer model answers each start
//                two cycles later, and a scoreboard of expected layer starts
//                (layer_id, sample_index) is compared with observed starts.
//                A second instance with MAX_BATCH_SIZE=1 is driven directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_layer;
   import neural_burning_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   decode_layer_if #(.INSTRUCTION_SIZE(12), .LAYER_ID_WIDTH(4), .SAMPLE_WIDTH(2)) bus  ();
   decode_layer_if #(.INSTRUCTION_SIZE(12), .LAYER_ID_WIDTH(4), .SAMPLE_WIDTH(1)) bus1 ();

   decode_layer #(.INSTRUCTION_SIZE(12), .MAX_BATCH_SIZE(3), .LAYER_ID_WIDTH(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   decode_layer #(.INSTRUCTION_SIZE(12), .MAX_BATCH_SIZE(1), .LAYER_ID_WIDTH(4)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- fetch model: advance only while stop is low ----------
   logic [11:0] prog [0:7];
   int          prog_len = 0;
   int          pc;
   int          adv_cnt;
   logic        fetch_en = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pc                    <= 0;
         adv_cnt               <= 0;
         bus.instruction       <= 12'h000;
         bus.instruction_valid <= 1'b0;
      end else if (fetch_en && !bus.stop) begin
         adv_cnt <= adv_cnt + 1;
         if (pc < prog_len) begin
            bus.instruction <= prog[pc];
            pc              <= pc + 1;
         end else begin
            bus.instruction <= 12'h000;
         end
         bus.instruction_valid <= 1'b1;
      end
   end

   // ---------------- layer model: done two cycles after start -------------
   logic resp_done = 1'b0;
   logic man_done  = 1'b0;
   logic auto_done = 1'b1;
   int   resp_cnt  = 0;

   always @(negedge clk) begin
      resp_done <= (resp_cnt == 1);
      if (bus.layer_start && auto_done) resp_cnt <= 2;
      else if (resp_cnt != 0)           resp_cnt <= resp_cnt - 1;
   end
   assign bus.layer_done = resp_done | man_done;

   // ---------------- start monitors ----------------------------------------
   logic [3:0] got_id  [0:63];
   logic [1:0] got_smp [0:63];
   int         got_wr  = 0;
   int         got_rd  = 0;
   int         starts1 = 0;

   always @(negedge clk) begin
      if (bus.layer_start) begin
         got_id[got_wr[5:0]]  <= bus.layer_id;
         got_smp[got_wr[5:0]] <= bus.sample_index;
         got_wr               <= got_wr + 1;
      end
      if (bus1.layer_start) starts1 <= starts1 + 1;
   end

   // ---------------- scoreboard --------------------------------------------
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] smp;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_forward(input logic [3:0] id);
      for (int s = 0; s < 3; s++) exp_q.push_back('{id: id, smp: 2'(s)});
   endtask

   task automatic drain(input string tag);
      exp_t e;
      check({tag, " start_count"}, 32'(got_wr - got_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_rd < got_wr) begin
         e = exp_q.pop_front();
         check({tag, " layer_id"},     32'(got_id[got_rd[5:0]]),  32'(e.id));
         check({tag, " sample_index"}, 32'(got_smp[got_rd[5:0]]), 32'(e.smp));
         got_rd++;
      end
      exp_q.delete();
      got_rd = got_wr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      fetch_en = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      got_rd = got_wr;
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         if (got_wr - got_rd >= n) break;
         @(negedge clk); #1;
      end
      check({tag, " starts_reached"}, 32'(got_wr - got_rd >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (!bus.busy && !bus.stop) break;
      end
      check({tag, " returned_idle"}, 32'(bus.busy), 32'd0);
   endtask

   int bad;

   initial begin
      bus1.instruction       = 12'h000;
      bus1.instruction_valid = 1'b0;
      bus1.layer_done        = 1'b0;

      // ---- 1: reset state and quiet idle ----
      repeat (3) @(negedge clk);
      #1;
      check("t1 rst stop",        32'(bus.stop),         32'd0);
      check("t1 rst busy",        32'(bus.busy),         32'd0);
      check("t1 rst halted",      32'(bus.halted),       32'd0);
      check("t1 rst illegal",     32'(bus.illegal_op),   32'd0);
      check("t1 rst layer_start", 32'(bus.layer_start),  32'd0);
      check("t1 rst layer_id",    32'(bus.layer_id),     32'd0);
      check("t1 rst sample",      32'(bus.sample_index), 32'd0);
      reset = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (bus.stop || bus.busy || bus.layer_start) bad++;
      end
      check("t1 idle_quiet", 32'(bad), 32'd0);
      drain("t1");

      // ---- 2: single FORWARD, layer 3, three samples ----
      prog[0] = 12'h130; prog_len = 1;
      push_forward(4'h3);
      fetch_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (bus.instruction_valid && bus.instruction == 12'h130) break;
      end
      check("t2 stop_on_decode", 32'(bus.stop), 32'd1);
      check("t2 adv_at_decode",  32'(adv_cnt),  32'd1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (bus.layer_done && bus.sample_index == 2'd2) break;
         if (!bus.stop) bad++;
      end
      check("t2 last_done_seen",    32'(bus.layer_done), 32'd1);
      check("t2 stop_at_last_done", 32'(bus.stop),       32'd0);
      check("t2 stop_held",         32'(bad),            32'd0);
      @(negedge clk); #1;
      check("t2 single_advance", 32'(adv_cnt),          32'd2);
      check("t2 busy_after",     32'(bus.busy),         32'd0);
      check("t2 sample_wrap",    32'(bus.sample_index), 32'd0);
      drain("t2");

      // ---- 3: program FORWARD, FORWARD, HALT ----
      do_reset();
      prog[0] = 12'h120; prog[1] = 12'h150; prog[2] = 12'h200; prog_len = 3;
      push_forward(4'h2);
      push_forward(4'h5);
      fetch_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (bus.halted) break;
      end
      check("t3 halted",   32'(bus.halted), 32'd1);
      check("t3 consumed", 32'(pc),         32'd3);
      drain("t3");
      bad = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (!bus.stop || !bus.halted || bus.busy || pc != 3) bad++;
      end
      check("t3 halt_hold", 32'(bad), 32'd0);
      check("t3 no_starts_halted", 32'(got_wr - got_rd), 32'd0);

      // ---- 4: illegal opcode, then NOP ----
      do_reset();
      check("t4 illegal_cleared", 32'(bus.illegal_op), 32'd0);
      prog[0] = 12'h700; prog[1] = 12'h000; prog_len = 2;
      fetch_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (bus.instruction_valid && bus.instruction == 12'h700) break;
      end
      check("t4 stop_on_illegal", 32'(bus.stop),       32'd0);
      check("t4 illegal_pre",     32'(bus.illegal_op), 32'd0);
      @(negedge clk); #1;
      check("t4 illegal_set", 32'(bus.illegal_op), 32'd1);
      repeat (5) @(negedge clk);
      #1;
      check("t4 illegal_sticky", 32'(bus.illegal_op), 32'd1);
      check("t4 busy",           32'(bus.busy),       32'd0);
      drain("t4");

      // ---- 5: async reset in WAIT_DONE at sample 1 ----
      do_reset();
      prog[0] = 12'h150; prog_len = 1;
      push_forward(4'h5);
      fetch_en = 1'b1;
      wait_starts(2, 40, "t5 pre");
      @(negedge clk);
      #2;
      check("t5 pre_busy",   32'(bus.busy),         32'd1);
      check("t5 pre_sample", 32'(bus.sample_index), 32'd1);
      reset = 1'b1;
      #1;
      check("t5 async busy",     32'(bus.busy),         32'd0);
      check("t5 async sample",   32'(bus.sample_index), 32'd0);
      check("t5 async layer_id", 32'(bus.layer_id),     32'd0);
      check("t5 async stop",     32'(bus.stop),         32'd0);
      check("t5 async start",    32'(bus.layer_start),  32'd0);
      #1;
      reset = 1'b0;
      exp_q.delete();
      got_rd = got_wr;
      push_forward(4'h5);
      @(negedge clk); #1;
      check("t5 stale_done_present", 32'(bus.layer_done),   32'd1);
      check("t5 stale_sample",       32'(bus.sample_index), 32'd0);
      check("t5 stale_busy",         32'(bus.busy),         32'd0);
      wait_starts(3, 60, "t5 rerun");
      wait_idle(20, "t5");
      drain("t5");

      // ---- 6a: spurious layer_done in IDLE and ISSUE ----
      do_reset();
      @(negedge clk);
      man_done = 1'b1;
      #1;
      check("t6 idle_done_stop", 32'(bus.stop), 32'd0);
      @(negedge clk);
      man_done = 1'b0;
      #1;
      check("t6 idle_done_sample", 32'(bus.sample_index), 32'd0);
      check("t6 idle_done_busy",   32'(bus.busy),         32'd0);
      auto_done = 1'b0;
      prog[0] = 12'h1A0; prog_len = 1;
      push_forward(4'hA);
      fetch_en = 1'b1;
      wait_starts(1, 20, "t6 issue");
      man_done = 1'b1;
      #1;
      check("t6 issue_done_stop", 32'(bus.stop), 32'd1);
      @(negedge clk);
      man_done = 1'b0;
      #1;
      check("t6 issue_done_busy",   32'(bus.busy),         32'd1);
      check("t6 issue_done_sample", 32'(bus.sample_index), 32'd0);
      check("t6 issue_done_start",  32'(bus.layer_start),  32'd0);
      for (int s = 0; s < 3; s++) begin
         man_done = 1'b1;
         @(negedge clk);
         man_done = 1'b0;
         if (s < 2) @(negedge clk);
      end
      #1;
      check("t6 issue_end_busy",   32'(bus.busy),         32'd0);
      check("t6 issue_end_sample", 32'(bus.sample_index), 32'd0);
      drain("t6 issue");
      auto_done = 1'b1;

      // ---- 6b: MAX_BATCH_SIZE = 1 ----
      @(negedge clk);
      bus1.instruction       = 12'h130;
      bus1.instruction_valid = 1'b1;
      #1;
      check("t6b stop_on_decode", 32'(bus1.stop), 32'd1);
      @(negedge clk); #1;
      check("t6b start",    32'(bus1.layer_start),  32'd1);
      check("t6b layer_id", 32'(bus1.layer_id),     32'd3);
      check("t6b sample",   32'(bus1.sample_index), 32'd0);
      @(negedge clk); #1;
      check("t6b wait_busy", 32'(bus1.busy), 32'd1);
      bus1.layer_done = 1'b1;
      #1;
      check("t6b stop_first_done", 32'(bus1.stop), 32'd0);
      @(negedge clk);
      bus1.layer_done  = 1'b0;
      bus1.instruction = 12'h000;
      #1;
      check("t6b busy_after",   32'(bus1.busy),         32'd0);
      check("t6b sample_after", 32'(bus1.sample_index), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("t6b single_start", 32'(starts1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
